// File: rtl/imem_fetch_port_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_fetch_port_pkg;

  localparam int XLEN       = 32;
  localparam int IMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

  // A fetch is illegal when not word aligned or past the last word.
  function automatic logic fetch_err(input logic [XLEN-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= XLEN'(depth));
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch, response, flush and loader signals between the IF stage and the fetch port.
interface imem_fetch_port_if;
  import imem_fetch_port_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] rsp_addr;
  logic            rsp_err;
  logic            flush;
  logic            wr_en;
  logic            wr_ready;
  logic [XLEN-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, wr_ready
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, wr_ready
  );

endinterface

// File: rtl/imem_fetch_port_array.sv
// 1R1W synchronous-read instruction RAM; the read register doubles as the rsp_data register.
module imem_fetch_port_array
  import imem_fetch_port_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en_i,
  input  logic            rd_zero_i,
  input  logic [AW-1:0]   rd_idx_i,
  output logic [XLEN-1:0] rd_data_o,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_idx_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rd_data_q;

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read register: loaded only when a fetch is accepted, so it holds through wait and stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= {XLEN{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= rd_zero_i ? {XLEN{1'b0}} : mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction-memory fetch port: valid/ready fetch channel, wait states, flush and word loader.
module imem_fetch_port
  import imem_fetch_port_pkg::*;
#(
  parameter int DEPTH       = IMEM_DEPTH,
  parameter int WAIT_CYCLES = 0
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_port_if.slave bus
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [2:0]  WAIT_LOAD    = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
  localparam imem_state_e LAUNCH_STATE = (WAIT_CYCLES > 0) ? IMEM_WAIT : IMEM_RESP;

  imem_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_addr_q;

  logic req_ready_s;
  logic req_fire_s;
  logic req_err_s;
  logic wr_ready_s;
  logic wr_fire_s;

  assign req_ready_s = !bus.flush &&
                       ((state_q == IMEM_IDLE) || ((state_q == IMEM_RESP) && bus.rsp_ready));
  assign req_fire_s  = bus.req_valid && req_ready_s;
  assign req_err_s   = fetch_err(bus.req_addr, DEPTH);
  assign wr_ready_s  = (state_q == IMEM_IDLE) && !bus.req_valid;
  assign wr_fire_s   = bus.wr_en && wr_ready_s && ((bus.wr_addr >> 2) < XLEN'(DEPTH));

  // Next-state and wait-counter logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IMEM_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IMEM_IDLE: begin
          if (req_fire_s) begin
            state_d = LAUNCH_STATE;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = IMEM_IDLE;
          end
        end
        IMEM_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_d = IMEM_RESP;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        IMEM_RESP: begin
          if (req_fire_s) begin
            state_d = LAUNCH_STATE;
            cnt_d   = WAIT_LOAD;
          end else if (bus.rsp_ready) begin
            state_d = IMEM_IDLE;
          end else begin
            state_d = IMEM_RESP;
          end
        end
        default: begin
          state_d = IMEM_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response sideband registers; addr/err captured at accept and held until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_addr_q  <= {XLEN{1'b0}};
    end else begin
      rsp_valid_q <= (state_d == IMEM_RESP);
      if (req_fire_s) begin
        rsp_err_q  <= req_err_s;
        rsp_addr_q <= bus.req_addr;
      end
    end
  end

  imem_fetch_port_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (req_fire_s),
    .rd_zero_i (req_err_s),
    .rd_idx_i  (bus.req_addr[AW+1:2]),
    .rd_data_o (bus.rsp_data),
    .wr_en_i   (wr_fire_s),
    .wr_idx_i  (bus.wr_addr[AW+1:2]),
    .wr_data_i (bus.wr_data)
  );

  assign bus.req_ready = req_ready_s;
  assign bus.wr_ready  = wr_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Drives a zero-wait and a three-wait fetch port with shared stimulus and checks both against a transaction-level model.
module tb_imem_fetch_port;
  import imem_fetch_port_pkg::*;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] PROG_WORD = 32'h0062E233;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        flush     = 1'b0;
  logic        wr_en     = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] wr_addr   = 32'h0;
  logic [31:0] wr_data   = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_fetch_port_if bus0 ();
  imem_fetch_port_if bus3 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_addr  = req_addr;
  assign bus0.rsp_ready = rsp_ready;
  assign bus0.flush     = flush;
  assign bus0.wr_en     = wr_en;
  assign bus0.wr_addr   = wr_addr;
  assign bus0.wr_data   = wr_data;
  assign bus3.req_valid = req_valid;
  assign bus3.req_addr  = req_addr;
  assign bus3.rsp_ready = rsp_ready;
  assign bus3.flush     = flush;
  assign bus3.wr_en     = wr_en;
  assign bus3.wr_addr   = wr_addr;
  assign bus3.wr_data   = wr_data;

  imem_fetch_port #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst(rst), .bus(bus0));
  imem_fetch_port #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (.clk(clk), .rst(rst), .bus(bus3));

  logic        o_valid [2];
  logic        o_rr    [2];
  logic        o_wr    [2];
  logic        o_err   [2];
  logic [31:0] o_data  [2];
  logic [31:0] o_addr  [2];

  assign o_valid[0] = bus0.rsp_valid;
  assign o_rr[0]    = bus0.req_ready;
  assign o_wr[0]    = bus0.wr_ready;
  assign o_err[0]   = bus0.rsp_err;
  assign o_data[0]  = bus0.rsp_data;
  assign o_addr[0]  = bus0.rsp_addr;
  assign o_valid[1] = bus3.rsp_valid;
  assign o_rr[1]    = bus3.req_ready;
  assign o_wr[1]    = bus3.wr_ready;
  assign o_err[1]   = bus3.rsp_err;
  assign o_data[1]  = bus3.rsp_data;
  assign o_addr[1]  = bus3.rsp_addr;

  // Model: one outstanding fetch per port, counted down in whole cycles.
  int          wait_of [2] = '{0, 3};
  bit          m_busy  [2];
  bit          m_valid [2];
  bit          m_err   [2];
  int          m_cnt   [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] mem_m   [2][DEPTH];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k]  = 1'b0;
      m_valid[k] = 1'b0;
      m_cnt[k]   = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit    exp_rr, exp_wr;
    string p;
    p      = $sformatf("w%0d_", wait_of[k]);
    exp_rr = !flush && (!m_busy[k] || (m_valid[k] && rsp_ready));
    exp_wr = !m_busy[k] && !req_valid;
    chk_eq({p, "rsp_valid"}, 32'(o_valid[k]), 32'(m_valid[k]));
    chk_eq({p, "req_ready"}, 32'(o_rr[k]), 32'(exp_rr));
    chk_eq({p, "wr_ready"}, 32'(o_wr[k]), 32'(exp_wr));
    if (m_valid[k]) begin
      chk_eq({p, "rsp_data"}, o_data[k], m_data[k]);
      chk_eq({p, "rsp_addr"}, o_addr[k], m_addr[k]);
      chk_eq({p, "rsp_err"}, 32'(o_err[k]), 32'(m_err[k]));
    end
    if (flush) begin
      m_busy[k]  = 1'b0;
      m_valid[k] = 1'b0;
    end else if (req_valid && exp_rr) begin
      m_busy[k]  = 1'b1;
      m_cnt[k]   = wait_of[k];
      m_valid[k] = (wait_of[k] == 0);
      m_addr[k]  = req_addr;
      m_err[k]   = (req_addr % 4 != 0) || (req_addr / 4 >= 32'(DEPTH));
      m_data[k]  = m_err[k] ? 32'h0 : mem_m[k][req_addr / 4];
    end else if (m_valid[k] && rsp_ready) begin
      m_busy[k]  = 1'b0;
      m_valid[k] = 1'b0;
    end else if (m_busy[k] && !m_valid[k]) begin
      m_cnt[k]   = m_cnt[k] - 1;
      m_valid[k] = (m_cnt[k] == 0);
    end
    if (wr_en && exp_wr && (wr_addr / 4 < 32'(DEPTH))) begin
      mem_m[k][wr_addr / 4] = wr_data;
    end
  endtask

  // Inputs are set just after a rising edge; checks and model update run on the falling edge.
  task automatic drive(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                       input bit we, input logic [31:0] wa, input logic [31:0] wd);
    req_valid = rv;
    req_addr  = ra;
    rsp_ready = rr;
    flush     = fl;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk_eq({tag, "_valid"}, 32'(o_valid[k]), 32'h0);
      chk_eq({tag, "_err"}, 32'(o_err[k]), 32'h0);
      chk_eq({tag, "_data"}, o_data[k], 32'h0);
      chk_eq({tag, "_addr"}, o_addr[k], 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill the whole array so every later read has a defined value.
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'(i) << 2;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a | 32'($urandom_range(0, 3)), $urandom);
    end

    // Program word then fetch it on the zero-wait port.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, PROG_WORD);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t1_valid", 32'(o_valid[0]), 32'h1);
    chk_eq("t1_data", o_data[0], PROG_WORD);
    chk_eq("t1_err", 32'(o_err[0]), 32'h0);
    idle(5, 1'b1);

    // Three wait states: response appears on the fourth cycle after the request.
    drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t2_lat0", 32'(o_valid[1]), 32'h0);
    for (int i = 1; i < 3; i++) begin
      idle(1, 1'b0);
      chk_eq("t2_lat", 32'(o_valid[1]), 32'h0);
    end
    idle(1, 1'b0);
    chk_eq("t2_valid", 32'(o_valid[1]), 32'h1);
    chk_eq("t2_data", o_data[1], mem_m[1][1]);
    idle(5, 1'b1);

    // Back-to-back fetches with the second response stalled for two cycles.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_eq("t3_hold_addr", o_addr[0], 32'h4);
      chk_eq("t3_hold_data", o_data[0], mem_m[0][1]);
    end
    drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t3_third_addr", o_addr[0], 32'h8);
    idle(6, 1'b1);

    // Misaligned and out-of-range fetches.
    drive(1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t4_mis_err", 32'(o_err[0]), 32'h1);
    chk_eq("t4_mis_data", o_data[0], 32'h0);
    drive(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t4_oor_err", 32'(o_err[0]), 32'h1);
    chk_eq("t4_oor_data", o_data[0], 32'h0);
    chk_eq("t4_oor_addr", o_addr[0], 32'h1000);
    idle(6, 1'b1);

    // Flush with a pending response and a live request, then re-request.
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk_eq("t5_flushed", 32'(o_valid[0]), 32'h0);
    drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t5_rereq_valid", 32'(o_valid[0]), 32'h1);
    chk_eq("t5_rereq_addr", o_addr[0], 32'hC);
    idle(6, 1'b1);

    // Asynchronous reset while the three-wait port is waiting.
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6, 1'b1);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_eq("t6_mem_kept", o_data[0], PROG_WORD);
    idle(6, 1'b1);

    // Random traffic; word 0 is never rewritten so it stays a known value.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else               a = 32'(DEPTH + $urandom_range(0, 3000)) << 2;
      drive(($urandom_range(0, 9) < 6), a, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0) ? (32'(DEPTH + $urandom_range(0, 100)) << 2)
                                        : ((32'($urandom_range(1, 15)) << 2) | 32'($urandom_range(0, 3))),
            $urandom);
    end
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
